matmul_operand_packer_4x4: RTL

//  Write side for the 4x4 matrix multiplier: packs a byte-serial stream of matrix elements into
//  one 16-element packed matrix word and presents it on a valid/ready output. The output feeds
//  the multiplier's A or B operand. Double-buffered, so a new matrix streams in while the

---
 rtl/matmul_operand_packer_4x4.sv | 113 +++++++++++
 1 files changed

// File: rtl/matmul_operand_packer_4x4.sv
// Byte-serial to packed 4x4 matrix packer with a one-deep output slot and framing-error detection.
// State | meaning:  FILL | assembling elements into slots;  DRAIN | discarding an over-long frame until s_last
module matmul_operand_packer_4x4 #(
    parameter int W         = 8,
    parameter bit COL_MAJOR = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [W-1:0]    s_data,
    input  logic            s_valid,
    input  logic            s_last,
    output logic            s_ready,
    output logic [16*W-1:0] m_matrix,
    output logic            m_valid,
    input  logic            m_ready,
    output logic            err_short,
    output logic            err_long,
    output logic [15:0]     frame_cnt
);

    typedef enum logic {FILL = 1'b0, DRAIN = 1'b1} state_t;

    state_t          state, state_nxt;
    logic [3:0]      idx, idx_nxt, slot;
    logic [16*W-1:0] asm_q, asm_nxt;
    logic            beat, fill_beat, load, handshake;
    logic            short_nxt, long_nxt;

    // Column-major beat k lands in row k%4, column k/4, i.e. slot 4*(k%4)+k/4.
    assign slot      = COL_MAJOR ? {idx[1:0], idx[3:2]} : idx;
    assign handshake = m_valid && m_ready;
    assign s_ready   = (state == DRAIN) || !((idx == 4'd15) && m_valid && !m_ready);
    assign beat      = s_valid && s_ready;
    assign fill_beat = beat && (state == FILL);
    assign load      = fill_beat && (idx == 4'd15);

    always_comb begin
        asm_nxt = asm_q;
        for (int i = 0; i < 16; i++) begin
            if (fill_beat && (int'(slot) == i)) begin
                asm_nxt[W*(15-i) +: W] = s_data;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        short_nxt = 1'b0;
        long_nxt  = 1'b0;
        case (state)
            FILL: begin
                if (beat) begin
                    if (idx == 4'd15) begin
                        idx_nxt = 4'd0;
                        if (!s_last) begin
                            long_nxt  = 1'b1;
                            state_nxt = DRAIN;
                        end
                    end else if (s_last) begin
                        idx_nxt   = 4'd0;
                        short_nxt = 1'b1;
                    end else begin
                        idx_nxt = idx + 4'd1;
                    end
                end
            end
            DRAIN: begin
                if (beat && s_last) begin
                    state_nxt = FILL;
                    idx_nxt   = 4'd0;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= FILL;
            idx       <= 4'd0;
            asm_q     <= '0;
            err_short <= 1'b0;
            err_long  <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            asm_q     <= asm_nxt;
            err_short <= short_nxt;
            err_long  <= long_nxt;
        end
    end

    // The output slot only loads when empty or being drained this cycle; s_ready enforces that.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_matrix  <= '0;
            m_valid   <= 1'b0;
            frame_cnt <= 16'd0;
        end else begin
            if (load) begin
                m_matrix <= asm_nxt;
                m_valid  <= 1'b1;
            end else if (handshake) begin
                m_valid <= 1'b0;
            end
            if (handshake) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

endmodule
